// File: rtl/wb_slave_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_slave_pkg
// Description : Register map, STATUS/CTRL bit positions and ack FSM encoding
//               shared by the WISHBONE register slave.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_slave_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_DIVIDER = 3'd1;
    localparam logic [2:0] REG_TXDATA  = 3'd2;
    localparam logic [2:0] REG_RXDATA  = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;

    localparam int STAT_TX_VALID = 0;
    localparam int STAT_RX_FULL  = 1;
    localparam int STAT_TX_OVF   = 2;
    localparam int STAT_RX_OVF   = 3;

    localparam int CTRL_IRQ_EN = 7;
    localparam int CTRL_RX_IE  = 6;
    localparam int CTRL_TX_IE  = 5;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } ack_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_slave_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_slave_regs_if
// Description : WISHBONE classic bus bundle between master and register slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_slave_regs_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADR_WIDTH  = 32
);
    logic                  stb;
    logic                  we;
    logic [ADR_WIDTH-1:0]  adr;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  ack;

    modport master (output stb, we, adr, din, input dout, ack);
    modport slave  (input stb, we, adr, din, output dout, ack);
endinterface
`default_nettype wire

// File: rtl/wb_slave_regs_ack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_slave_ack_ctrl
// Description : IDLE/WAIT/ACK sequencer; inserts WAIT_STATES cycles, then a
//               one-cycle commit strobe that coincides with the ack-setting edge.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_slave_ack_ctrl
    import wb_slave_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_stb,
    output logic o_ack,
    output logic o_commit
);

    localparam logic [WAIT_CNT_W-1:0] C_CNT_INIT =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    ack_state_e            r_state;
    ack_state_e            w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [WAIT_CNT_W-1:0] w_cnt_nxt;
    logic                  r_ack;
    logic                  w_commit;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_stb) begin
                    if (WAIT_STATES > 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = C_CNT_INIT;
                    end else begin
                        w_state_nxt = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                // A dropped strobe abandons the access before anything commits
                if (!i_stb) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_ACK: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_commit;
        end
    end

    assign o_ack    = r_ack;
    assign o_commit = w_commit;

endmodule
`default_nettype wire

// File: rtl/wb_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : wb_slave_regs
// Description : WISHBONE classic register slave holding SPI CTRL, DIVIDER,
//               TX and RX holding registers. Optional macro: WB_SLAVE_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_slave_regs
    import wb_slave_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADR_WIDTH   = 32,
    parameter int WAIT_STATES = 0
) (
    input  wire                   clk,
    input  wire                   rst,
    wb_slave_regs_if.slave        bus,
    output logic [DATA_WIDTH-1:0] ctrl_o,
    output logic [DATA_WIDTH-1:0] div_o,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  wire                   tx_ready,
    input  wire  [DATA_WIDTH-1:0] rx_data,
    input  wire                   rx_valid,
    output logic                  irq
);

    localparam logic [DATA_WIDTH-1:0] C_CTRL_IRQ_BITS =
        DATA_WIDTH'((1 << CTRL_IRQ_EN) | (1 << CTRL_RX_IE) | (1 << CTRL_TX_IE));
`ifdef WB_SLAVE_IRQ_EN
    localparam logic [DATA_WIDTH-1:0] C_CTRL_WMASK = '1;
`else
    localparam logic [DATA_WIDTH-1:0] C_CTRL_WMASK = ~C_CTRL_IRQ_BITS;
`endif

    logic                  w_commit;
    logic                  w_ack;
    logic [2:0]            w_adr;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_tx_wr;
    logic                  w_tx_consume;
    logic                  w_rx_rd;
    logic                  w_st_wr;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_adr;

    logic [DATA_WIDTH-1:0] r_ctrl;
    logic [DATA_WIDTH-1:0] r_div;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_full;
    logic                  r_tx_ovf;
    logic                  r_rx_ovf;
    logic [DATA_WIDTH-1:0] r_dout;

    wb_slave_ack_ctrl #(
        .WAIT_STATES (WAIT_STATES)
    ) u_ack_ctrl (
        .clk      (clk),
        .rst      (rst),
        .i_stb    (bus.stb),
        .o_ack    (w_ack),
        .o_commit (w_commit)
    );

    // Upper address bits are qualified by the upstream decoder through stb
    assign w_unused_adr = ^bus.adr[ADR_WIDTH-1:3];
    assign w_adr        = bus.adr[2:0];
    assign w_wr         = w_commit & bus.we;
    assign w_rd         = w_commit & ~bus.we;
    assign w_tx_wr      = w_wr & (w_adr == REG_TXDATA);
    assign w_st_wr      = w_wr & (w_adr == REG_STATUS);
    assign w_rx_rd      = w_rd & (w_adr == REG_RXDATA);
    assign w_tx_consume = r_tx_valid & tx_ready;

    always_comb begin
        w_status                = '0;
        w_status[STAT_TX_VALID] = r_tx_valid;
        w_status[STAT_RX_FULL]  = r_rx_full;
        w_status[STAT_TX_OVF]   = r_tx_ovf;
        w_status[STAT_RX_OVF]   = r_rx_ovf;
    end

    always_comb begin
        w_rdata = '0;
        case (w_adr)
            REG_CTRL:    w_rdata = r_ctrl;
            REG_DIVIDER: w_rdata = r_div;
            REG_TXDATA:  w_rdata = r_tx_data;
            REG_RXDATA:  w_rdata = r_rx_data;
            REG_STATUS:  w_rdata = w_status;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_div      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_rx_full  <= 1'b0;
            r_tx_ovf   <= 1'b0;
            r_rx_ovf   <= 1'b0;
            r_dout     <= '0;
        end else begin
            if (w_rd) r_dout <= w_rdata;
            if (w_wr && (w_adr == REG_CTRL))    r_ctrl <= bus.din & C_CTRL_WMASK;
            if (w_wr && (w_adr == REG_DIVIDER)) r_div  <= bus.din;

            if (w_st_wr && bus.din[STAT_TX_OVF]) r_tx_ovf <= 1'b0;
            if (w_st_wr && bus.din[STAT_RX_OVF]) r_rx_ovf <= 1'b0;

            // A full holding register only accepts new data if it drains this edge
            if (w_tx_wr && r_tx_valid && !w_tx_consume) begin
                r_tx_ovf <= 1'b1;
            end else if (w_tx_wr) begin
                r_tx_data  <= bus.din;
                r_tx_valid <= 1'b1;
            end else if (w_tx_consume) begin
                r_tx_valid <= 1'b0;
            end

            if (rx_valid) begin
                r_rx_data <= rx_data;
                r_rx_full <= 1'b1;
                if (r_rx_full) r_rx_ovf <= 1'b1;
            end else if (w_rx_rd) begin
                r_rx_full <= 1'b0;
            end
        end
    end

`ifdef WB_SLAVE_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_ctrl[CTRL_IRQ_EN] &
                     ((r_ctrl[CTRL_RX_IE] & r_rx_full) |
                      (r_ctrl[CTRL_TX_IE] & ~r_tx_valid) |
                      r_tx_ovf | r_rx_ovf);
        end
    end
    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    assign bus.dout = r_dout;
    assign bus.ack  = w_ack;
    assign ctrl_o   = r_ctrl;
    assign div_o    = r_div;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule
`default_nettype wire
